rr_arbiter4: RTL and testbench

Round-robin arbiter that shares one resource among 4 requesters. The winner's 2-bit index is registered and decoded through the 2-input minterm decode (z3..z0) into a one-hot grant vector. Ownership is held while the request stays high. An optional hold limit forces rotation when other requesters are waiting. It sits in front of any shared datapath resource, such as a bus or register-file port, in the chapter's sequential examples.

---
 rtl/rr_arbiter4.sv | 128 ++++++++++++
 tb/tb_rr_arbiter4.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 - four-way round-robin arbiter for a shared resource.
//
// The winner's 2-bit index is registered and decoded into a one-hot grant.
// An owner keeps the grant while its request stays high. When other
// requesters are waiting, the owner is rotated out after MAX_HOLD
// consecutive cycles.
//
// Ports:
//   clock    in   1  system clock, rising edge
//   reset_   in   1  asynchronous active-low reset
//   req      in   4  level-sensitive request lines
//   gnt      out  4  one-hot grant, all zero when idle
//   gnt_idx  out  2  encoded owner index, meaningful only while busy
//   busy     out  1  a requester currently holds the grant
//   preempt  out  1  one-cycle pulse in the cycle after a hold-limit rotation
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no owner; the next request wins after one edge
// GRANT | gnt_idx owns the resource; busy=1

module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_preempt, w_preempt_nxt;
    logic [3:0]       w_owner_oh;
    logic [3:0]       w_others;
    logic [1:0]       w_idx_inc;

    // First requester found when searching upward from start, wrapping at 3.
    // The loop runs from the farthest offset to the nearest, so the nearest
    // match is the one that is kept.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] c;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            c = start + 2'(k);
            if (r[c]) pick = c;
        end
    endfunction

    assign w_owner_oh = 4'b0001 << r_idx;
    assign w_others   = req & ~w_owner_oh;
    assign w_idx_inc  = r_idx + 2'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_preempt_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = pick(req, r_ptr);
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req[r_idx]) begin
                    w_ptr_nxt = w_idx_inc;
                    w_cnt_nxt = '0;
                    if (|w_others) begin
                        w_idx_nxt = pick(w_others, w_idx_inc);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_cnt == HOLD_LAST && |w_others) begin
                    // The owner is masked out of the search, so it cannot
                    // win its own rotation.
                    w_idx_nxt     = pick(w_others, w_idx_inc);
                    w_ptr_nxt     = w_idx_inc;
                    w_cnt_nxt     = '0;
                    w_preempt_nxt = 1'b1;
                end else if (r_cnt != HOLD_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_ptr     <= 2'd0;
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    // Every output is derived only from flops, so there is no combinational
    // path from req to the grant.
    assign busy    = (r_state == GRANT);
    assign gnt_idx = r_idx;
    assign preempt = r_preempt;
    assign gnt[3]  = busy &  r_idx[1] &  r_idx[0];
    assign gnt[2]  = busy &  r_idx[1] & ~r_idx[0];
    assign gnt[1]  = busy & ~r_idx[1] &  r_idx[0];
    assign gnt[0]  = busy & ~r_idx[1] & ~r_idx[0];

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic       clock;
    logic       reset_;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(3)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every requester asserted.
        reset_ = 1'b0;
        req    = 4'b1111;
        #12;
        chk("rst_gnt",  gnt, 4'b0000);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_idx",  {2'b0, gnt_idx}, 4'd0);
        chk("rst_pre",  {3'b0, preempt}, 4'd0);
        @(negedge clock);
        reset_ = 1'b1;
        step();
        chk("rel_gnt", gnt, 4'b0001);
        chk("rel_idx", {2'b0, gnt_idx}, 4'd0);

        // Constant full contention: 8 cycles per owner, preempt at each switch.
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                if (k == 4 && c > 0) break;
                if (!(k == 0 && c == 0)) step();
                chk($sformatf("rot_gnt_k%0d_c%0d", k, c), gnt, 4'b0001 << (k % 4));
                chk($sformatf("rot_pre_k%0d_c%0d", k, c), {3'b0, preempt},
                    (c == 0 && k > 0) ? 4'd1 : 4'd0);
            end
        end
        req = 4'b0000;
        step();
        chk("rot_idle_busy", {3'b0, busy}, 4'd0);
        chk("rot_idle_gnt", gnt, 4'b0000);

        // Lone requester keeps the grant indefinitely.
        req = 4'b0100;
        step();
        chk("one_gnt",  gnt, 4'b0100);
        chk("one_busy", {3'b0, busy}, 4'd1);
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("one_hold_gnt_%0d", c), gnt, 4'b0100);
            chk($sformatf("one_hold_pre_%0d", c), {3'b0, preempt}, 4'd0);
        end
        req = 4'b0000;
        step();
        chk("one_drop_busy", {3'b0, busy}, 4'd0);
        chk("one_drop_gnt", gnt, 4'b0000);

        // Handover chain 0 -> 1 -> 3 -> 0 with no idle bubble.
        req = 4'b0011;
        step();
        chk("ho_own0", gnt, 4'b0001);
        req = 4'b0010;
        step();
        chk("ho_to1", gnt, 4'b0010);
        chk("ho_to1_busy", {3'b0, busy}, 4'd1);
        req = 4'b1010;
        step();
        chk("ho_keep1", gnt, 4'b0010);
        req = 4'b1000;
        step();
        chk("ho_to3", gnt, 4'b1000);
        chk("ho_to3_idx", {2'b0, gnt_idx}, 4'd3);
        req = 4'b1001;
        step();
        chk("ho_keep3", gnt, 4'b1000);
        req = 4'b0001;
        step();
        chk("ho_wrap0", gnt, 4'b0001);
        chk("ho_wrap0_pre", {3'b0, preempt}, 4'd0);
        req = 4'b0000;
        step();
        chk("ho_idle", gnt, 4'b0000);

        // Fairness: releasing owner 1 leaves the pointer at 2.
        req = 4'b0010;
        step();
        chk("fair_own1", gnt, 4'b0010);
        req = 4'b0000;
        step();
        chk("fair_idle", {3'b0, busy}, 4'd0);
        req = 4'b1011;
        step();
        chk("fair_gnt", gnt, 4'b1000);
        chk("fair_idx", {2'b0, gnt_idx}, 4'd3);
        req = 4'b0000;
        step();

        // Asynchronous reset while owner 2 is mid-hold.
        req = 4'b0100;
        step();
        chk("ar_own2", gnt, 4'b0100);
        for (int c = 0; c < 5; c++) step();
        chk("ar_own2_held", gnt, 4'b0100);
        #2;
        reset_ = 1'b0;
        #1;
        chk("ar_gnt",  gnt, 4'b0000);
        chk("ar_busy", {3'b0, busy}, 4'd0);
        chk("ar_idx",  {2'b0, gnt_idx}, 4'd0);
        req = 4'b1100;
        #1;
        reset_ = 1'b1;
        step();
        chk("ar_regrant", gnt, 4'b0100);
        for (int c = 1; c < 8; c++) begin
            step();
            chk($sformatf("ar_hold_%0d", c), gnt, 4'b0100);
            chk($sformatf("ar_hold_pre_%0d", c), {3'b0, preempt}, 4'd0);
        end
        step();
        chk("ar_rot_gnt", gnt, 4'b1000);
        chk("ar_rot_pre", {3'b0, preempt}, 4'd1);
        step();
        chk("ar_pre_pulse", {3'b0, preempt}, 4'd0);
        chk("ar_keep3", gnt, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
